// File: rtl/mem_arbiter.sv
// Two-port request/acknowledge arbiter sharing one single-port synchronous memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   tie_gnt;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign tie_gnt = 1'b0;
`else
    logic last_q, last_d;

    // last resets to 1 so port 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == RESP) begin
            last_d = gnt_q;
        end
    end

    assign tie_gnt = ~last_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACCESS;
                    gnt_d   = (req0 && req1) ? tie_gnt : req1;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state plus the granted port's stable fields
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        if (state_q == ACCESS) begin
            mem_en    = 1'b1;
            mem_we    = gnt_q ? we1 : we0;
            mem_addr  = gnt_q ? addr1 : addr0;
            mem_wdata = gnt_q ? wdata1 : wdata0;
        end
        if (state_q == RESP) begin
            if (gnt_q) begin
                ack1   = 1'b1;
                rdata1 = mem_rdata;
            end else begin
                ack0   = 1'b1;
                rdata0 = mem_rdata;
            end
        end
    end

    assign busy = (state_q == ACCESS) || (state_q == RESP);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural synchronous memory, ack scoreboard
// and cycle-exact checks of latency, arbitration order, reset and idle behaviour.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1, mem_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
    logic          ack0, ack1, mem_en, mem_we, busy;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] mem [0:255];

    typedef struct {
        int            port;
        bit            chk;
        logic [DW-1:0] data;
    } sb_t;

    sb_t sbq[$];
    sb_t sbItem;

    logic [11:0] pat0, pat1;
    logic [5:0]  enPat, a0Pat, a1Pat;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // behavioural single-port memory with one cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushExpect(input int port, input bit chk, input logic [DW-1:0] data);
        sb_t s;
        s.port = port;
        s.chk  = chk;
        s.data = data;
        sbq.push_back(s);
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 0) begin
            req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end
    endtask

    // called at the start of an IDLE cycle with the request already driven
    task automatic expectAccess(input int port, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata);
        @(negedge clk);
        checkOutput("c0_mem_en", mem_en, 1'b0);
        @(negedge clk);
        checkOutput("c1_mem_en", mem_en, 1'b1);
        checkOutput("c1_mem_we", mem_we, we);
        checkOutput("c1_mem_addr", mem_addr, addr);
        if (we) checkOutput("c1_mem_wdata", mem_wdata, wdata);
        checkOutput("c1_busy", busy, 1'b1);
        checkOutput("c1_acks", {ack1, ack0}, 2'b00);
        @(negedge clk);
        checkOutput("c2_ack", (port == 1) ? ack1 : ack0, 1'b1);
        checkOutput("c2_other_ack", (port == 1) ? ack0 : ack1, 1'b0);
        checkOutput("c2_mem_en", mem_en, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // every ack pulse is matched against the oldest expected completion
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            checkOutput("ack_exclusive", {63'd0, ack0 & ack1}, 64'd0);
            if (sbq.size() == 0) begin
                checkOutput("sb_unexpected_ack", {62'd0, ack1, ack0}, 64'd0);
            end else begin
                sbItem = sbq.pop_front();
                checkOutput("sb_port", ack1 ? 64'd1 : 64'd0, 64'(sbItem.port));
                if (sbItem.chk) checkOutput("sb_rdata", (sbItem.port == 1) ? rdata1 : rdata0, sbItem.data);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0101_0101 * i;
        mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h20] = 32'h0000_0000;
        mem[8'h30] = 32'hA0A0_A0A0;
        mem[8'h40] = 32'hB1B1_B1B1;
        mem[8'h44] = 32'hC2C2_C2C2;
        mem_rdata  = '0;

        reset = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_ctrl_outs", {busy, mem_en, mem_we, ack0, ack1}, 5'b0);
        checkOutput("rst_mem_addr", mem_addr, '0);
        checkOutput("rst_rdata", {rdata0, rdata1}, '0);
        @(posedge clk);
        #1;

        $display("[TB] single read on port 0");
        pushExpect(0, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, '0);
        expectAccess(0, 1'b0, 32'h10, '0);
        applyStimulus(0, 1'b0, 1'b0, '0, '0);

        $display("[TB] write then read on port 1 with req held");
        pushExpect(1, 1'b0, '0);
        applyStimulus(1, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        expectAccess(1, 1'b1, 32'h20, 32'h1234_5678);
        pushExpect(1, 1'b1, 32'h1234_5678);
        applyStimulus(1, 1'b1, 1'b0, 32'h20, '0);
        expectAccess(1, 1'b0, 32'h20, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);

        $display("[TB] contention from reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) pushExpect(0, 1'b1, 32'hA0A0_A0A0);
`else
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) pushExpect(0, 1'b1, 32'hA0A0_A0A0);
            else            pushExpect(1, 1'b1, 32'hB1B1_B1B1);
        end
`endif
        applyStimulus(0, 1'b1, 1'b0, 32'h30, '0);
        applyStimulus(1, 1'b1, 1'b0, 32'h40, '0);
        pat0 = '0;
        pat1 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            pat0[c] = ack0;
            pat1[c] = ack1;
        end
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
`ifdef MEM_ARB_FIXED_PRIO_EN
        checkOutput("contend_ack0_cycles", pat0, 12'h924);
        checkOutput("contend_ack1_cycles", pat1, 12'h000);
`else
        checkOutput("contend_ack0_cycles", pat0, 12'h104);
        checkOutput("contend_ack1_cycles", pat1, 12'h820);
`endif

        $display("[TB] late request during port 0 access");
        pushExpect(0, 1'b1, 32'hDEAD_BEEF);
        pushExpect(1, 1'b1, 32'hC2C2_C2C2);
        enPat = '0;
        a0Pat = '0;
        a1Pat = '0;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) applyStimulus(0, 1'b1, 1'b0, 32'h10, '0);
            if (c == 1) applyStimulus(1, 1'b1, 1'b0, 32'h44, '0);
            if (c == 3) applyStimulus(0, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            enPat[c] = mem_en;
            a0Pat[c] = ack0;
            a1Pat[c] = ack1;
            @(posedge clk);
            #1;
        end
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        checkOutput("late_mem_en_cycles", enPat, 6'h12);
        checkOutput("late_ack0_cycles", a0Pat, 6'h04);
        checkOutput("late_ack1_cycles", a1Pat, 6'h20);

        $display("[TB] reset during access");
        pushExpect(0, 1'b1, 32'hDEAD_BEEF);
        enPat = '0;
        a0Pat = '0;
        a1Pat = '0;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) applyStimulus(0, 1'b1, 1'b0, 32'h10, '0);
            if (c == 1) reset = 1'b1;
            if (c == 2) reset = 1'b0;
            if (c == 5) applyStimulus(0, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (c == 2) checkOutput("rst_mid_outs", {mem_en, busy, ack0, ack1}, 4'b0);
            enPat[c] = mem_en;
            a0Pat[c] = ack0;
            a1Pat[c] = ack1;
            @(posedge clk);
            #1;
        end
        checkOutput("rst_mid_mem_en_cycles", enPat, 6'h0A);
        checkOutput("rst_mid_ack0_cycles", a0Pat, 6'h10);
        checkOutput("rst_mid_ack1_cycles", a1Pat, 6'h00);

        $display("[TB] idle outputs with fields driven but no request");
        applyStimulus(0, 1'b0, 1'b1, 32'h55, 32'h5555_5555);
        applyStimulus(1, 1'b0, 1'b1, 32'h66, 32'h6666_6666);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("idle_ctrl_outs", {mem_en, mem_we, busy, ack0, ack1}, 5'b0);
            checkOutput("idle_mem_addr", mem_addr, '0);
        end

        checkOutput("sb_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port synchronous memory between two requesters: the processor data port (port 0) and a loader/DMA master (port 1). Each requester uses a request/acknowledge handshake. The arbiter grants one access at a time, drives the memory, and returns an acknowledge pulse with read data. It sits between the `processor` data-memory outputs (`WE`, `address_to_mem`, `data_to_mem`, `data_from_mem`) and the physical data memory.

## Interface
- `ADDR_W`, 32, address width of requesters and memory
- `DATA_W`, 32, data width of requesters and memory
- `clk  input  1  rising-edge clock`
- `reset  input  1  synchronous, active-high reset`
- `req0, req1  input  1  access request per port; held until that port's ack`
- `we0, we1  input  1  1 = write, 0 = read; stable while req high`
- `addr0, addr1  input  ADDR_W  access address; stable while req high`
- `wdata0, wdata1  input  DATA_W  write data; stable while req high`
- `ack0, ack1  output  1  one-cycle completion pulse per port`
- `rdata0, rdata1  output  DATA_W  read data, valid only while matching ack high`
- `mem_en  output  1  memory access strobe`
- `mem_we  output  1  memory write enable, only meaningful with mem_en`
- `mem_addr  output  ADDR_W  memory address`
- `mem_wdata  output  DATA_W  memory write data`
- `mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en`
- `busy  output  1  high in ACCESS and RESP`

## Operation
- FSM states: IDLE, ACCESS, RESP. Registers: `state`, `gnt` (1 bit, port being served), `last` (1 bit, port most recently served).
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: `gnt` = that port, go to ACCESS.
  - Both req: `gnt` = `~last` (round-robin), go to ACCESS.
- ACCESS (one cycle):
  - `mem_en` = 1.
  - `mem_we`, `mem_addr`, `mem_wdata` are muxed combinationally from port `gnt`.
  - Go to RESP.
- RESP (one cycle):
  - `ack[gnt]` = 1 and `rdata[gnt]` = `mem_rdata`; the non-granted ack stays 0.
  - `last` <= `gnt`. Go to IDLE.
  - For writes, ack is still issued; rdata content is don't-care.
- Requester rules:
  - May deassert req in the cycle after its ack, or hold it high to request the next access with new fields.
  - Dropping req before ack is illegal. The arbiter still completes the latched access and pulses ack.
- Outside ACCESS: `mem_en` = 0, `mem_we` = 0, `mem_addr` and `mem_wdata` = 0.
- Outside RESP: both acks are 0 and both rdata outputs are 0.

## Timing
- Reset values: `state` = IDLE, `gnt` = 0, `last` = 1 (port 0 wins the first tie). All outputs are 0.
- Latency: req sampled high in IDLE at cycle N, giving `mem_en` in cycle N+1 and ack in cycle N+2.
- Throughput: at most one access per 3 cycles. A port holding req continuously completes one access every 3 cycles when uncontested.
- Both ports contending continuously: grants alternate 0,1,0,1…; no port waits more than one foreign access.
- Request arriving during ACCESS or RESP: ignored until the next IDLE cycle.
- Simultaneous new req and ack in RESP: the new request is evaluated in the following IDLE cycle, not in RESP.
- Reset mid-operation (in ACCESS or RESP): the next cycle is IDLE with all outputs 0 and no ack. An in-flight write may or may not have reached memory if reset was sampled at the end of ACCESS. The requester must reissue.
- All state changes occur on the rising edge of `clk`. The ack and `mem_*` outputs are decoded from registered state, with no combinational path from req to any output.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`:
  - Defined: on a tie, port 0 always wins and `last` is unused. Port 1 can starve.
  - Undefined (default): round-robin via `last`, as described above.

## Test plan
- Single read: port 0 requests a read at 0x10, memory holds 0xDEADBEEF there → `mem_en` high in cycle 1 with `mem_addr` = 0x10, `mem_we` = 0; `ack0` = 1 and `rdata0` = 0xDEADBEEF in cycle 2; `ack1` = 0 throughout.
- Write then read: port 1 writes 0x12345678 to 0x20, then reads 0x20 → `mem_we` = 1 with `mem_wdata` = 0x12345678 on the first access; the second ack returns `rdata1` = 0x12345678.
- Contention from reset: both ports hold req high for 12 cycles → acks in cycles 2, 5, 8, 11 alternate ack0, ack1, ack0, ack1. With `MEM_ARB_FIXED_PRIO_EN` defined, all four are ack0.
- Late request: port 1 raises req during port 0's ACCESS cycle → port 1's `mem_en` occurs 2 cycles after ack0, never overlapping.
- Reset mid-access: assert reset during ACCESS → the next cycle is IDLE, `mem_en` = 0, no ack pulses. After release with req0 held, ack0 arrives 2 cycles after the first IDLE.
- Idle outputs: no requests for 10 cycles → `mem_en`, `mem_we`, `busy`, `ack0`, `ack1` are 0 and `mem_addr` = 0 in every cycle.
